// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// Runs a 32-step shift-add multiply or a restoring divide and stalls the front
// end until the result is ready for the EX/MEM register.
// Optional feature: define MULDIV_EARLY_OUT_EN to let a multiply leave CALC as
// soon as the remaining multiplier bits are all zero.
module ex_muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hold,
    input  logic        kill,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic        signA_q, signA_d;
    logic        signB_q, signB_d;
    logic [5:0]  cnt_q, cnt_d;
    // Multiply: product accumulator. Divide: partial remainder in [32:0].
    logic [63:0] acc_q, acc_d;
    // Multiply: shifting multiplicand. Divide: divisor in [31:0].
    logic [63:0] mcand_q, mcand_d;
    // Multiply: shifting multiplier. Divide: dividend shifting into quotient.
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] result_q, result_d;
    logic        busy_q, done_q;

    logic        takeSignA, takeSignB, negA, negB;
    logic [31:0] magA, magB;
    logic        divZero, divOverflow;
    logic [63:0] accStep, prodFinal;
    logic [32:0] remShift, remStep;
    logic [33:0] remDiff;
    logic        remOk;
    logic [31:0] quotStep, quotFinal, remFinal;
    logic        lastStep;

    // Operand decode in IDLE plus one multiply step and one divide step per cycle.
    always_comb begin
        takeSignA   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
        takeSignB   = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        negA        = takeSignA && a[31];
        negB        = takeSignB && b[31];
        magA        = negA ? (32'd0 - a) : a;
        magB        = negB ? (32'd0 - b) : b;
        divZero     = funct3[2] && (b == 32'd0);
        divOverflow = funct3[2] && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

        accStep   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        prodFinal = (signA_q ^ signB_q) ? (64'd0 - accStep) : accStep;

        remShift  = {acc_q[31:0], mplier_q[31]};
        remDiff   = {1'b0, remShift} - {2'b00, mcand_q[31:0]};
        remOk     = !remDiff[33];
        remStep   = remOk ? remDiff[32:0] : remShift;
        quotStep  = {mplier_q[30:0], remOk};
        quotFinal = (signA_q ^ signB_q) ? (32'd0 - quotStep) : quotStep;
        remFinal  = signA_q ? (32'd0 - remStep[31:0]) : remStep[31:0];

`ifdef MULDIV_EARLY_OUT_EN
        lastStep = (cnt_q == 6'd31) || (!op_q[2] && (mplier_q[31:1] == 31'd0));
`else
        lastStep = (cnt_q == 6'd31);
`endif
    end

    // Next-state and datapath update; kill overrides everything and leaves result alone.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        signA_d  = signA_q;
        signB_d  = signB_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;

        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (divZero) begin
                            result_d = funct3[1] ? a : 32'hFFFF_FFFF;
                            state_d  = DONE;
                        end else if (divOverflow) begin
                            result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
                            state_d  = DONE;
                        end else begin
                            op_d    = funct3;
                            signA_d = negA;
                            signB_d = negB;
                            cnt_d   = 6'd0;
                            acc_d   = 64'd0;
                            if (funct3[2]) begin
                                mplier_d = magA;
                                mcand_d  = {32'd0, magB};
                            end else begin
                                mplier_d = magB;
                                mcand_d  = {32'd0, magA};
                            end
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + 6'd1;
                    if (op_q[2]) begin
                        acc_d    = {31'd0, remStep};
                        mplier_d = quotStep;
                    end else begin
                        acc_d    = accStep;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                    if (lastStep) begin
                        case (op_q)
                            3'b000:                 result_d = prodFinal[31:0];
                            3'b001, 3'b010, 3'b011: result_d = prodFinal[63:32];
                            3'b100, 3'b101:         result_d = quotFinal;
                            default:                result_d = remFinal;
                        endcase
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (!hold) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and registered status flags with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            signA_q  <= 1'b0;
            signB_q  <= 1'b0;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            signA_q  <= signA_d;
            signB_q  <= signB_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            busy_q   <= (state_d == CALC);
            done_q   <= (state_d == DONE);
        end
    end

    assign stall  = rst && req && (state_q != DONE) && !kill;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
